// File: rtl/time_set_ctrl.sv
`timescale 1ns/1ps
// time_set_ctrl
// Button-driven time-entry controller for the RTC initial-time load port.
// The user presses set to start editing (fields are seeded from the running
// RTC), adjusts hours and then minutes with inc/dec, and a final set commits
// both fields with a one-cycle load strobe. An edit with no button activity
// for TIMEOUT_CYCLES is abandoned without a strobe.
//
// Optional feature: define TIME_SET_AUTOREPEAT_EN to build inc/dec
// auto-repeat (HOLD_CYCLES before the first repeat, then one every
// REPEAT_CYCLES while held, edit states only). Without the macro, a press
// gives exactly one event and the repeat counters do not exist.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   btn_set/btn_inc/btn_dec   raw asynchronous button levels, active-high
//   rtc_hh, rtc_mm            current RTC time (seed values, IDLE display)
//   initial_time_hh/_mm       last committed time (registered)
//   initial_time_valid        one-cycle load strobe (COMMIT state)
//   disp_hh, disp_mm          RTC time in IDLE, edit registers otherwise
//   blank_hh, blank_mm        blink blanking of the field being edited
//   editing                   high in EDIT_HH and EDIT_MM
//   dbg_state_o               current FSM state (IDLE/EDIT_HH/EDIT_MM/COMMIT)
//
// Handshake: initial_time_valid is a valid-only strobe with no ready; the
// RTC must accept initial_time_hh/_mm in the cycle the strobe is high.
module time_set_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int BLINK_HALF     = 250,
    parameter int HOLD_CYCLES    = 500,
    parameter int REPEAT_CYCLES  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] rtc_hh,
    input  logic [5:0] rtc_mm,
    output logic [4:0] initial_time_hh,
    output logic [5:0] initial_time_mm,
    output logic       initial_time_valid,
    output logic [4:0] disp_hh,
    output logic [5:0] disp_mm,
    output logic       blank_hh,
    output logic       blank_mm,
    output logic       editing,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EDIT_HH = 2'd1,
        EDIT_MM = 2'd2,
        COMMIT  = 2'd3
    } state_e;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(2 * BLINK_HALF);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BLINK_ON   = BW'(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);

    state_e state_q, state_d;
    logic [4:0] edit_hh_q, edit_hh_d;
    logic [5:0] edit_mm_q, edit_mm_d;
    logic [4:0] init_hh_q;
    logic [5:0] init_mm_q;
    logic [TW-1:0] tmo_q;
    logic [BW-1:0] blink_q;
    logic load_commit;

    // Button conditioning, bit order {dec, inc, set}. The edge detector
    // output is registered so an event lands one cycle after the second
    // synchronizer stage sees the press.
    logic [2:0] sync1_q, sync2_q, prev_q, ev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ev_q    <= '0;
        end else begin
            sync1_q <= {btn_dec, btn_inc, btn_set};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            ev_q    <= sync2_q & ~prev_q;
        end
    end

    logic in_edit;
    assign in_edit = (state_q == EDIT_HH) || (state_q == EDIT_MM);

    logic set_ev, inc_ev, dec_ev;
    assign set_ev = ev_q[0];

`ifdef TIME_SET_AUTOREPEAT_EN
    // Hold counters run while the synchronized level is high. On reaching
    // HOLD_CYCLES a repeat fires and the counter reloads so the next one
    // comes REPEAT_CYCLES later.
    localparam int RW = $clog2(HOLD_CYCLES + 1);
    localparam logic [RW-1:0] HOLD_V   = RW'(HOLD_CYCLES);
    localparam logic [RW-1:0] RELOAD_V = RW'(HOLD_CYCLES - REPEAT_CYCLES);

    logic [RW-1:0] rinc_q, rdec_q;
    logic rep_inc, rep_dec;
    assign rep_inc = in_edit && sync2_q[1] && (rinc_q == HOLD_V);
    assign rep_dec = in_edit && sync2_q[2] && (rdec_q == HOLD_V);

    always_ff @(posedge clk) begin
        if (rst || !in_edit) begin
            rinc_q <= '0;
            rdec_q <= '0;
        end else begin
            if (!sync2_q[1])   rinc_q <= '0;
            else if (rep_inc)  rinc_q <= RELOAD_V;
            else               rinc_q <= rinc_q + 1'b1;
            if (!sync2_q[2])   rdec_q <= '0;
            else if (rep_dec)  rdec_q <= RELOAD_V;
            else               rdec_q <= rdec_q + 1'b1;
        end
    end

    assign inc_ev = ev_q[1] | rep_inc;
    assign dec_ev = ev_q[2] | rep_dec;
`else
    assign inc_ev = ev_q[1];
    assign dec_ev = ev_q[2];
`endif

    logic any_ev, tmo_hit;
    assign any_ev  = set_ev | inc_ev | dec_ev;
    assign tmo_hit = (tmo_q == TMO_LIMIT);

    // Out-of-range values wrap to 0 on inc and to the maximum on dec.
    function automatic logic [4:0] hh_step(input logic [4:0] v, input logic up);
        if (up) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] mm_step(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        edit_hh_d   = edit_hh_q;
        edit_mm_d   = edit_mm_q;
        load_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_ev) begin
                    state_d   = EDIT_HH;
                    edit_hh_d = rtc_hh;
                    edit_mm_d = rtc_mm;
                end
            end
            EDIT_HH: begin
                if (set_ev)                 state_d = EDIT_MM;
                else if (tmo_hit)           state_d = IDLE;
                else if (inc_ev && !dec_ev) edit_hh_d = hh_step(edit_hh_q, 1'b1);
                else if (dec_ev && !inc_ev) edit_hh_d = hh_step(edit_hh_q, 1'b0);
            end
            EDIT_MM: begin
                if (set_ev) begin
                    state_d     = COMMIT;
                    load_commit = 1'b1;
                end
                else if (tmo_hit)           state_d = IDLE;
                else if (inc_ev && !dec_ev) edit_mm_d = mm_step(edit_mm_q, 1'b1);
                else if (dec_ev && !inc_ev) edit_mm_d = mm_step(edit_mm_q, 1'b0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            edit_hh_q <= '0;
            edit_mm_q <= '0;
            init_hh_q <= '0;
            init_mm_q <= '0;
            tmo_q     <= '0;
            blink_q   <= '0;
        end else begin
            state_q   <= state_d;
            edit_hh_q <= edit_hh_d;
            edit_mm_q <= edit_mm_d;
            if (load_commit) begin
                init_hh_q <= edit_hh_q;
                init_mm_q <= edit_mm_q;
            end
            if (!in_edit || any_ev) tmo_q <= '0;
            else                    tmo_q <= tmo_q + 1'b1;
            // Restart the blink phase on field entry and on every adjustment
            // so the edited value is shown immediately.
            if ((state_d != state_q) || inc_ev || dec_ev) blink_q <= '0;
            else if (blink_q == BLINK_LAST)               blink_q <= '0;
            else                                          blink_q <= blink_q + 1'b1;
        end
    end

    assign initial_time_hh    = init_hh_q;
    assign initial_time_mm    = init_mm_q;
    assign initial_time_valid = (state_q == COMMIT);
    assign disp_hh            = (state_q == IDLE) ? rtc_hh : edit_hh_q;
    assign disp_mm            = (state_q == IDLE) ? rtc_mm : edit_mm_q;
    assign blank_hh           = (state_q == EDIT_HH) && (blink_q >= BLINK_ON);
    assign blank_mm           = (state_q == EDIT_MM) && (blink_q >= BLINK_ON);
    assign editing            = in_edit;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
`timescale 1ns/1ps
module tb_time_set_ctrl;

  localparam int TMO   = 60;
  localparam int BLINK = 4;
  localparam int HOLD  = 20;
  localparam int REP   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       btn_set = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [4:0] rtc_hh = 5'd0;
  logic [5:0] rtc_mm = 6'd0;
  logic [4:0] initial_time_hh, disp_hh;
  logic [5:0] initial_time_mm, disp_mm;
  logic       initial_time_valid, blank_hh, blank_mm, editing;
  logic [1:0] dbg_state;

  time_set_ctrl #(
    .TIMEOUT_CYCLES(TMO), .BLINK_HALF(BLINK),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .rtc_hh(rtc_hh), .rtc_mm(rtc_mm),
    .initial_time_hh(initial_time_hh), .initial_time_mm(initial_time_mm),
    .initial_time_valid(initial_time_valid),
    .disp_hh(disp_hh), .disp_mm(disp_mm),
    .blank_hh(blank_hh), .blank_mm(blank_mm),
    .editing(editing), .dbg_state_o(dbg_state)
  );

  int n_pass = 0;
  int n_total = 0;

  // strobe monitor
  int   valid_seen = 0;
  int   valid_double = 0;
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (initial_time_valid) begin
      valid_seen++;
      if (valid_prev) valid_double++;
    end
    valid_prev = initial_time_valid;
  end

  // driver tasks (called at #1 after a rising edge)
  task automatic press(input logic s, input logic i, input logic d);
    btn_set = s; btn_inc = i; btn_dec = d;
    repeat (3) @(posedge clk);
    #1;
    btn_set = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presses set from EDIT_MM and expects exactly one strobe cycle.
  task automatic press_commit(input logic [4:0] ehh, input logic [5:0] emm, input string name);
    bit found = 0;
    btn_set = 1'b1;
    for (int k = 0; k < 12 && !found; k++) begin
      @(posedge clk);
      #1;
      if (initial_time_valid) begin
        found = 1;
        n_total++;
        if (initial_time_hh !== ehh || initial_time_mm !== emm)
          $display("FAIL %s_value got %0d:%0d exp %0d:%0d", name, initial_time_hh, initial_time_mm, ehh, emm);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (initial_time_valid !== 1'b0 || dbg_state !== 2'd0)
          $display("FAIL %s_after got valid=%0b state=%0d exp valid=0 state=0", name, initial_time_valid, dbg_state);
        else n_pass++;
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL %s_strobe got no strobe within 12 cycles exp one", name);
    end
    btn_set = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_reset();
    rtc_hh = 5'd10; rtc_mm = 6'd30;
    rst = 1'b1;
    idle_cycles(3);
    n_total++;
    if (initial_time_hh !== 5'd0 || initial_time_mm !== 6'd0 || initial_time_valid !== 1'b0)
      $display("FAIL reset_init got %0d:%0d v=%0b exp 0:0 v=0", initial_time_hh, initial_time_mm, initial_time_valid);
    else n_pass++;
    n_total++;
    if (editing !== 1'b0 || blank_hh !== 1'b0 || blank_mm !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL reset_flags got ed=%0b bh=%0b bm=%0b st=%0d exp 0 0 0 0", editing, blank_hh, blank_mm, dbg_state);
    else n_pass++;
    n_total++;
    if (disp_hh !== 5'd10 || disp_mm !== 6'd30)
      $display("FAIL reset_disp got %0d:%0d exp 10:30", disp_hh, disp_mm);
    else n_pass++;
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic_edit();
    press(1, 0, 0);
    n_total++;
    if (editing !== 1'b1 || disp_hh !== 5'd10)
      $display("FAIL enter_edit got ed=%0b hh=%0d exp ed=1 hh=10", editing, disp_hh);
    else n_pass++;
    press(0, 1, 0);
    press(0, 1, 0);
    n_total++;
    if (disp_hh !== 5'd12) $display("FAIL inc_hh got %0d exp 12", disp_hh);
    else n_pass++;
    press(1, 0, 0);
    n_total++;
    if (dbg_state !== 2'd2 || disp_mm !== 6'd30)
      $display("FAIL to_edit_mm got st=%0d mm=%0d exp st=2 mm=30", dbg_state, disp_mm);
    else n_pass++;
    for (int k = 0; k < 31; k++) press(0, 0, 1);
    n_total++;
    if (disp_mm !== 6'd59) $display("FAIL dec_mm_wrap got %0d exp 59", disp_mm);
    else n_pass++;
    press_commit(5'd12, 6'd59, "commit_basic");
  endtask

  task automatic test_blink();
    int hi_hh = 0;
    int hi_mm = 0;
    rtc_hh = 5'd1; rtc_mm = 6'd2;
    press(1, 0, 0);
    for (int k = 0; k < 16; k++) begin
      if (blank_hh) hi_hh++;
      if (blank_mm) hi_mm++;
      idle_cycles(1);
    end
    n_total++;
    if (hi_hh != 2 * BLINK || hi_mm != 0)
      $display("FAIL blink_hh got hh_on=%0d mm_on=%0d exp %0d 0", hi_hh, hi_mm, 2 * BLINK);
    else n_pass++;
    // leave via timeout
    idle_cycles(TMO + 10);
  endtask

  task automatic test_wrap();
    rtc_hh = 5'd23; rtc_mm = 6'd0;
    press(1, 0, 0);
    press(0, 1, 0);
    n_total++;
    if (disp_hh !== 5'd0) $display("FAIL inc_hh_wrap got %0d exp 0", disp_hh);
    else n_pass++;
    press(1, 0, 0);
    press(0, 0, 1);
    n_total++;
    if (disp_mm !== 6'd59) $display("FAIL dec_mm_zero got %0d exp 59", disp_mm);
    else n_pass++;
    press_commit(5'd0, 6'd59, "commit_wrap");
  endtask

  task automatic test_timeout();
    int seen0;
    rtc_hh = 5'd5; rtc_mm = 6'd6;
    seen0 = valid_seen;
    press(1, 0, 0);
    idle_cycles(40);
    n_total++;
    if (editing !== 1'b1) $display("FAIL timeout_early got ed=%0b exp 1", editing);
    else n_pass++;
    idle_cycles(40);
    n_total++;
    if (editing !== 1'b0 || dbg_state !== 2'd0 || valid_seen != seen0)
      $display("FAIL timeout_exit got ed=%0b st=%0d strobes=%0d exp 0 0 %0d", editing, dbg_state, valid_seen, seen0);
    else n_pass++;
    n_total++;
    if (initial_time_hh !== 5'd0 || initial_time_mm !== 6'd59)
      $display("FAIL timeout_hold got %0d:%0d exp 0:59", initial_time_hh, initial_time_mm);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    rtc_hh = 5'd7; rtc_mm = 6'd8;
    press(1, 0, 0);
    press(1, 1, 0);
    n_total++;
    if (dbg_state !== 2'd2 || disp_hh !== 5'd7)
      $display("FAIL set_inc got st=%0d hh=%0d exp st=2 hh=7", dbg_state, disp_hh);
    else n_pass++;
    press(0, 1, 1);
    n_total++;
    if (disp_mm !== 6'd8 || dbg_state !== 2'd2)
      $display("FAIL inc_dec got mm=%0d st=%0d exp mm=8 st=2", disp_mm, dbg_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen0;
    seen0 = valid_seen;
    rst = 1'b1;
    idle_cycles(1);
    n_total++;
    if (editing !== 1'b0 || dbg_state !== 2'd0 || initial_time_hh !== 5'd0 || initial_time_mm !== 6'd0)
      $display("FAIL reset_mid got ed=%0b st=%0d init=%0d:%0d exp 0 0 0:0", editing, dbg_state, initial_time_hh, initial_time_mm);
    else n_pass++;
    rst = 1'b0;
    rtc_hh = 5'd3; rtc_mm = 6'd0;
    idle_cycles(2);
    n_total++;
    if (valid_seen != seen0) $display("FAIL reset_strobe got %0d exp %0d", valid_seen, seen0);
    else n_pass++;
    press(1, 0, 0);
    n_total++;
    if (disp_hh !== 5'd3 || disp_mm !== 6'd0 || dbg_state !== 2'd1)
      $display("FAIL restart got %0d:%0d st=%0d exp 3:0 st=1", disp_hh, disp_mm, dbg_state);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [5:0] exp_mm;
`ifdef TIME_SET_AUTOREPEAT_EN
    exp_mm = 6'd5;
`else
    exp_mm = 6'd1;
`endif
    press(1, 0, 0);
    btn_inc = 1'b1;
    idle_cycles(1 + HOLD + 3 * REP);
    btn_inc = 1'b0;
    idle_cycles(6);
    n_total++;
    if (disp_mm !== exp_mm || dbg_state !== 2'd2)
      $display("FAIL hold_inc got mm=%0d st=%0d exp mm=%0d st=2", disp_mm, dbg_state, exp_mm);
    else n_pass++;
  endtask

  task automatic test_final();
    n_total++;
    if (valid_double != 0 || valid_seen != 2)
      $display("FAIL strobe_total got strobes=%0d doubles=%0d exp 2 0", valid_seen, valid_double);
    else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_edit();
    test_blink();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_hold();
    test_final();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time-entry controller that writes the RTC's initial-time load interface. It drives `initial_time_hh`, `initial_time_mm` and `initial_time_valid`. The user steps through hour and minute fields with set/inc/dec buttons. During editing, the block supplies the display path with the values being edited and a blink mask. It sits between the board buttons and the RTC, and its display outputs feed the existing BCD/7-segment chain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1000: cycles with no button event before an edit is abandoned.
- `BLINK_HALF`, 250: cycles per blink half-period.
- `HOLD_CYCLES`, 500: inc/dec hold time before auto-repeat starts (only with the macro defined).
- `REPEAT_CYCLES`, 100: auto-repeat interval (only with the macro defined).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_set`, `btn_inc`, `btn_dec`  in  1 each  raw button levels, asynchronous, active-high.
- `rtc_hh`  in  5  current RTC hours.
- `rtc_mm`  in  6  current RTC minutes.
- `initial_time_hh`  out  5  committed hours, registered.
- `initial_time_mm`  out  6  committed minutes, registered.
- `initial_time_valid`  out  1  one-cycle load strobe to the RTC.
- `disp_hh`, `disp_mm`  out  5/6  values to display:
  - `rtc_*` in IDLE;
  - edit registers otherwise.
- `blank_hh`, `blank_mm`  out  1 each  blank the field currently being edited during the off half of the blink.
- `editing`  out  1  high in EDIT_HH and EDIT_MM.

## Operation
- Each button passes through a 2-flop synchronizer and then a rising-edge detector, giving a 1-cycle internal event pulse per press.
- States and transitions:
  - IDLE:
    - set event → load `edit_hh <= rtc_hh`, `edit_mm <= rtc_mm`, go to EDIT_HH.
    - inc/dec events are ignored.
  - EDIT_HH:
    - inc: `edit_hh` 23→0, else +1.
    - dec: 0→23, else −1.
    - set → EDIT_MM.
  - EDIT_MM:
    - same inc/dec rules with modulus 60 (59→0, 0→59).
    - set → COMMIT.
  - COMMIT:
    - for exactly one cycle, register `initial_time_hh/mm <= edit_hh/mm` and assert `initial_time_valid`.
    - then go to IDLE.
- Simultaneous events:
  - set together with inc/dec: set wins, the value is unchanged, the state advances.
  - inc and dec together: no change.
- Out-of-range loads (`rtc_hh` > 23 or `rtc_mm` > 59) are loaded as-is. inc from an out-of-range value gives 0; dec gives the maximum (23/59).
- Timeout:
  - An idle counter runs in EDIT_HH and EDIT_MM and is cleared by any event.
  - When it reaches `TIMEOUT_CYCLES`, go to IDLE with no strobe; edits are discarded.
- Blink:
  - The counter is cleared on entry to EDIT_HH and EDIT_MM and on every inc/dec event.
  - The blank output for the active field is low for the first `BLINK_HALF` cycles, then high for `BLINK_HALF` cycles, repeating.
  - The other field is never blanked.
- `initial_time_hh/mm` hold the last committed value between commits.

## Timing
- Reset state:
  - state IDLE.
  - `initial_time_hh/mm` = 0.
  - `initial_time_valid` = 0.
  - edit registers 0.
  - `editing`, `blank_hh`, `blank_mm` = 0.
  - `disp_*` follows `rtc_*` combinationally.
- Press latency: a button high first sampled at edge N produces its event in the cycle after edge N+2. The state or value update is visible after edge N+3.
- The set event in EDIT_MM at cycle t puts COMMIT in cycle t+1. `initial_time_valid` and the new `initial_time_*` values are valid in t+1 only, and the state is IDLE at t+2.
- `initial_time_valid` is never high for more than one consecutive cycle.
- Reset asserted mid-edit or in COMMIT: the next cycle is IDLE, with no strobe and outputs at their reset values.
- A button held continuously generates exactly one event (no macro).

## Configuration
- `TIME_SET_AUTOREPEAT_EN` defined:
  - inc/dec held for `HOLD_CYCLES` after its event generates an extra event.
  - It then generates one every `REPEAT_CYCLES` while still held, in edit states only.
  - Releasing the button stops repeat immediately.
  - Repeat events reset the timeout and blink counters.
- Undefined: one event per press only; the repeat counters are not built.

## Test plan
- Reset, then `rtc_hh`=10, `rtc_mm`=30; press set → `editing`=1, `disp_hh`=10. Press inc ×2, set, dec ×31, set → one-cycle `initial_time_valid` with hh=12, mm=59.
- EDIT_HH at 23: inc → 0. EDIT_MM at 0: dec → 59. Commit → valid with those values.
- Enter edit, then no presses for `TIMEOUT_CYCLES` → IDLE, `editing`=0, no valid, `initial_time_*` unchanged.
- In EDIT_HH, set and inc in the same cycle → EDIT_MM with `edit_hh` unchanged. inc+dec same cycle in EDIT_MM → `edit_mm` unchanged.
- Assert `rst` during EDIT_MM → next cycle all outputs 0, no strobe. A subsequent set press restarts from `rtc_*`.
- Macro defined: hold inc in EDIT_MM from 0 for 1 + `HOLD_CYCLES` + 3×`REPEAT_CYCLES` cycles → `edit_mm`=5. Macro undefined: same stimulus → `edit_mm`=1.
